// File: rtl/asu_ddr5_wr_crc_framer_x4.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// asu_ddr5_wr_crc_framer_x4
//
// Write-path framer between the write-data block and the DQ serializer.
// Collects one 64-bit burst as 8 bytes over valid/ready, streams each
// accepted byte to the x4 write-CRC engine on the same edge, captures the
// engine's 8-bit code, then serialises the burst as 4-bit DQ beats:
// BL16 data followed by 2 CRC beats (BL18), or BL16 only with CRC disabled.
//
// Ports
//   clk_i         system clock, rising edge
//   rst_i         synchronous reset, active low (also resets the CRC engine)
//   crc_cfg_en_i  1 = append CRC; sampled with the first byte of a burst
//   wr_valid_i    write byte valid
//   wr_data_i     write byte
//   wr_ready_o    framer can accept a byte (FILL only)
//   crc_en_o      enable to the CRC engine
//   crc_data_o    byte to the CRC engine
//   crc_code_i    CRC code, valid the cycle after the 8th enabled byte
//   dq_o          DQ beat (DQ_IDLE when not valid)
//   dq_valid_o    dq_o carries a burst beat
//   burst_done_o  pulse coincident with the last beat of a burst
// -----------------------------------------------------------------------------
module asu_ddr5_wr_crc_framer_x4 #(
  parameter int unsigned BURST_BYTES = 8,
  parameter logic [3:0]  DQ_IDLE     = 4'h0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       crc_cfg_en_i,
  input  logic       wr_valid_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_ready_o,
  output logic       crc_en_o,
  output logic [7:0] crc_data_o,
  input  logic [7:0] crc_code_i,
  output logic [3:0] dq_o,
  output logic       dq_valid_o,
  output logic       burst_done_o
);

  localparam int unsigned DATA_BEATS = BURST_BYTES * 2;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    CRC_CAP = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t                        state;
  logic [2:0]                    byte_cnt;
  logic [4:0]                    beat_cnt;
  logic [BURST_BYTES-1:0][7:0]   data_buf;
  logic [7:0]                    crc_reg;
  logic                          crc_mode;

  logic                          accept;
  logic                          crc_mode_eff;
  logic [4:0]                    beat_nxt;
  logic [4:0]                    beat_last;

  // Beat b < 16 is nibble b of the little-endian burst; 16/17 are the CRC
  // low/high nibbles.
  function automatic logic [3:0] beat_sel(input logic [4:0]                  idx,
                                          input logic [BURST_BYTES*8-1:0]    data,
                                          input logic [7:0]                  crc);
    logic [3:0] nib;
    if (idx[4]) begin
      nib = idx[0] ? crc[7:4] : crc[3:0];
    end else begin
      nib = data[{idx[3:0], 2'b00} +: 4];
    end
    return nib;
  endfunction

  assign wr_ready_o   = (state == FILL);
  assign accept       = wr_valid_i & wr_ready_o;
  // The first byte of a burst uses the live config since crc_mode is only
  // latched on that same edge.
  assign crc_mode_eff = (byte_cnt == 3'd0) ? crc_cfg_en_i : crc_mode;
  // The extra enable in CRC_CAP returns the engine's sequence counter to 0.
  assign crc_en_o     = (accept & crc_mode_eff) | ((state == CRC_CAP) & crc_mode);
  assign crc_data_o   = accept ? wr_data_i : 8'h00;
  assign beat_last    = crc_mode ? 5'(DATA_BEATS + 1) : 5'(DATA_BEATS - 1);
  assign beat_nxt     = beat_cnt + 5'd1;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= FILL;
      byte_cnt     <= 3'd0;
      beat_cnt     <= 5'd0;
      data_buf     <= '0;
      crc_reg      <= 8'h00;
      crc_mode     <= 1'b0;
      dq_o         <= DQ_IDLE;
      dq_valid_o   <= 1'b0;
      burst_done_o <= 1'b0;
    end else begin
      case (state)
        // ---- fill: collect bytes, engine absorbs each on the same edge ----
        FILL: begin
          if (accept) begin
            data_buf[byte_cnt] <= wr_data_i;
            byte_cnt           <= byte_cnt + 3'd1;
            if (byte_cnt == 3'd0) begin
              crc_mode <= crc_cfg_en_i;
            end
            if (byte_cnt == 3'(BURST_BYTES - 1)) begin
              state <= CRC_CAP;
            end
          end
        end
        // ---- capture: one cycle in both modes so latency is fixed ----
        CRC_CAP: begin
          if (crc_mode) begin
            crc_reg <= crc_code_i;
          end
          dq_o         <= beat_sel(5'd0, data_buf, crc_reg);
          dq_valid_o   <= 1'b1;
          burst_done_o <= 1'b0;
          beat_cnt     <= 5'd0;
          state        <= SEND;
        end
        // ---- send: one beat per cycle, no backpressure ----
        SEND: begin
          if (beat_cnt == beat_last) begin
            dq_o         <= DQ_IDLE;
            dq_valid_o   <= 1'b0;
            burst_done_o <= 1'b0;
            byte_cnt     <= 3'd0;
            state        <= FILL;
          end else begin
            beat_cnt     <= beat_nxt;
            dq_o         <= beat_sel(beat_nxt, data_buf, crc_reg);
            burst_done_o <= (beat_nxt == beat_last);
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asu_ddr5_wr_crc_framer_x4.sv
`timescale 1ns/1ps
// Testbench for asu_ddr5_wr_crc_framer_x4: a behavioural CRC engine feeds
// crc_code_i, a negedge monitor collects DQ beats, and each burst is compared
// against the beat list derived from the bytes and the CRC-8 (x^8+x^2+x+1).
module tb_asu_ddr5_wr_crc_framer_x4;

  localparam logic [3:0] DQ_IDLE = 4'h0;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       crc_cfg_en_i;
  logic       wr_valid_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o;
  logic       crc_en_o;
  logic [7:0] crc_data_o;
  logic [7:0] crc_code_i;
  logic [3:0] dq_o;
  logic       dq_valid_o;
  logic       burst_done_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  asu_ddr5_wr_crc_framer_x4 #(
    .BURST_BYTES(8),
    .DQ_IDLE    (DQ_IDLE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .crc_cfg_en_i(crc_cfg_en_i),
    .wr_valid_i  (wr_valid_i),
    .wr_data_i   (wr_data_i),
    .wr_ready_o  (wr_ready_o),
    .crc_en_o    (crc_en_o),
    .crc_data_o  (crc_data_o),
    .crc_code_i  (crc_code_i),
    .dq_o        (dq_o),
    .dq_valid_o  (dq_valid_o),
    .burst_done_o(burst_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CRC of the 64-bit burst: bit n contributes x^(n+8) mod x^8+x^2+x+1.
  function automatic logic [7:0] crc8_ref(input logic [63:0] d);
    logic [7:0] p;
    logic [7:0] r;
    p = 8'h07;
    r = 8'h00;
    for (int n = 0; n < 64; n++) begin
      if (d[n]) r = r ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  // Behavioural CRC engine: absorbs 8 enabled bytes, presents the code while
  // its counter sits at 8, and a further enable returns it to 0. Outside that
  // window the code is deliberately wrong.
  int          eng_cnt;
  logic [63:0] eng_acc;
  logic [7:0]  junk;

  always @(posedge clk) begin
    junk <= 8'($urandom_range(1, 255));
    if (rst_i !== 1'b1) begin
      eng_cnt <= 0;
      eng_acc <= '0;
    end else if (crc_en_o) begin
      if (eng_cnt == 8) begin
        eng_cnt <= 0;
        eng_acc <= '0;
      end else begin
        eng_acc[eng_cnt*8 +: 8] <= crc_data_o;
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  assign crc_code_i = (eng_cnt == 8) ? crc8_ref(eng_acc) : (crc8_ref(eng_acc) ^ junk);

  // Monitor: only appends/increments; the driver works with snapshots.
  logic [3:0] obs_q[$];
  int         done_pos[$];
  int         en_cycles = 0;
  int         idle_bad  = 0;

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (crc_en_o) en_cycles++;
      if (dq_valid_o) begin
        obs_q.push_back(dq_o);
        if (burst_done_o) done_pos.push_back(obs_q.size() - 1);
      end else if (dq_o !== DQ_IDLE || burst_done_o !== 1'b0) begin
        idle_bad++;
      end
    end
  end

  // Drive one burst; gap of gap_len idle cycles is inserted before byte gap_at.
  task automatic run_burst(input string name, input logic [63:0] bytes, input bit cfg,
                           input int gap_at, input int gap_len, output logic [7:0] crc_obs);
    logic [3:0] exp_q[$];
    logic [7:0] crc_exp;
    int base, done_base, en_base, idle_base, n, nbeats;
    crc_exp = crc8_ref(bytes);
    for (int j = 0; j < 16; j++) exp_q.push_back(bytes[4*j +: 4]);
    if (cfg) begin
      exp_q.push_back(crc_exp[3:0]);
      exp_q.push_back(crc_exp[7:4]);
    end
    base      = obs_q.size();
    done_base = done_pos.size();
    en_base   = en_cycles;
    idle_base = idle_bad;
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          wr_valid_i   = 1'b0;
          wr_data_i    = 8'($urandom);
          crc_cfg_en_i = ~cfg;
          @(negedge clk);
          check({name, " gap crc_en"}, crc_en_o, 0);
          check({name, " gap crc_data"}, crc_data_o, 0);
        end
      end
      @(posedge clk); #1;
      wr_valid_i   = 1'b1;
      wr_data_i    = bytes[8*k +: 8];
      crc_cfg_en_i = (k == 0) ? cfg : ~cfg;
      @(negedge clk);
      check($sformatf("%s ready b%0d", name, k), wr_ready_o, 1);
      check($sformatf("%s crc_en b%0d", name, k), crc_en_o, cfg);
      check($sformatf("%s crc_data b%0d", name, k), crc_data_o, bytes[8*k +: 8]);
    end
    // Capture cycle: valid held high must not be accepted.
    @(posedge clk); #1;
    wr_valid_i = 1'b1;
    wr_data_i  = 8'($urandom);
    @(negedge clk);
    check({name, " cap ready"}, wr_ready_o, 0);
    check({name, " cap crc_en"}, crc_en_o, cfg);
    check({name, " cap crc_data"}, crc_data_o, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      wr_valid_i = (n < 4);
      wr_data_i  = 8'($urandom);
      @(negedge clk);
      n++;
    end while (!wr_ready_o && n <= 40);
    check({name, " ready latency"}, n + 1, cfg ? 20 : 18);
    nbeats = obs_q.size() - base;
    check({name, " beat count"}, nbeats, exp_q.size());
    for (int j = 0; j < exp_q.size() && j < nbeats; j++)
      check($sformatf("%s beat%0d", name, j), obs_q[base + j], exp_q[j]);
    check({name, " done count"}, done_pos.size() - done_base, 1);
    if (done_pos.size() - done_base == 1)
      check({name, " done beat"}, done_pos[done_base] - base, exp_q.size() - 1);
    check({name, " crc_en cycles"}, en_cycles - en_base, cfg ? 9 : 0);
    check({name, " idle dq"}, idle_bad - idle_base, 0);
    crc_obs = (nbeats >= 18) ? {obs_q[base + 17], obs_q[base + 16]} : 8'h00;
  endtask

  initial begin
    logic [7:0]  c;
    logic [7:0]  c_gap;
    logic [63:0] rb;
    int          base, n;

    rst_i        = 1'b0;
    wr_valid_i   = 1'b0;
    wr_data_i    = 8'h00;
    crc_cfg_en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    check("reset ready", wr_ready_o, 1);
    check("reset dq_valid", dq_valid_o, 0);
    check("reset dq", dq_o, DQ_IDLE);
    check("reset done", burst_done_o, 0);
    check("reset crc_en", crc_en_o, 0);
    check("reset crc_data", crc_data_o, 0);

    run_burst("zeros", 64'h0, 1'b1, 8, 0, c);
    check("zeros crc", c, 8'h00);
    run_burst("one", 64'h01, 1'b1, 8, 0, c);
    check("one crc", c, 8'h07);
    run_burst("msb", 64'h8000_0000_0000_0000, 1'b1, 8, 0, c);
    check("msb crc", c, 8'hBF);
    run_burst("a5 nocrc", 64'hA5, 1'b0, 8, 0, c);

    rb = {$urandom, $urandom};
    run_burst("nogap", rb, 1'b1, 8, 0, c);
    run_burst("gap", rb, 1'b1, 4, 3, c_gap);
    check("gap crc same", c_gap, c);

    // Reset in the middle of SEND, then a fresh burst must resynchronise.
    base = obs_q.size();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      wr_valid_i   = 1'b1;
      wr_data_i    = 8'($urandom);
      crc_cfg_en_i = 1'b1;
    end
    @(posedge clk); #1;
    wr_valid_i = 1'b0;
    n = 0;
    while (obs_q.size() < base + 5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst reached beat5", (n < 40), 1);
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1 rst_i = 1'b1;
    @(negedge clk);
    check("rst dq_valid", dq_valid_o, 0);
    check("rst dq", dq_o, DQ_IDLE);
    check("rst ready", wr_ready_o, 1);
    check("rst done", burst_done_o, 0);
    run_burst("post rst", 64'h01, 1'b1, 8, 0, c);
    check("post rst crc", c, 8'h07);

    for (int r = 0; r < 6; r++) begin
      rb = {$urandom, $urandom};
      run_burst($sformatf("rand%0d", r), rb, 1'($urandom_range(0, 1)),
                $urandom_range(0, 8), $urandom_range(1, 3), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
